// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   Clocked load/store controller sitting between the execute stage and a
//   single-beat handshaked memory port. One request is in flight at a time.
//
// Parameters
//   DW       data bus width (32 or 64)
//   AW       address width (at least 3)
//   TIMEOUT  cycles allowed in WAIT before an error response (>= 1)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        request handshake from execute
//   in_wen, in_addr, in_wdata  store flag, byte address, right-aligned data
//   in_wdt, in_sext            access width code (1<<wdt bytes), sign-extend
//   out_valid / out_ready      response handshake back to execute
//   out_rdata, out_err         load result (0 for stores), error flag
//   mem_req_*                  word-aligned request with byte-lane mask/data
//   mem_resp_valid, _rdata     read data or write acknowledge
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
   parameter int DW      = 64,
   parameter int AW      = 64,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_wen,
   input  logic [AW-1:0]   in_addr,
   input  logic [DW-1:0]   in_wdata,
   input  logic [1:0]      in_wdt,
   input  logic            in_sext,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_rdata,
   output logic            out_err,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic            mem_req_wen,
   output logic [AW-1:0]   mem_req_addr,
   output logic [DW-1:0]   mem_req_wdata,
   output logic [DW/8-1:0] mem_req_wmask,
   input  logic            mem_resp_valid,
   input  logic [DW-1:0]   mem_resp_rdata
);

   localparam int NB = DW / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state;
   state_t          next_state;

   logic            wen_q;
   logic [AW-1:0]   addr_q;
   logic [1:0]      wdt_q;
   logic            sext_q;
   logic [OW-1:0]   off_q;
   logic [DW-1:0]   wdata_q;
   logic [NB-1:0]   wmask_q;
   logic [DW-1:0]   rdata_q;
   logic            err_q;
   logic [CW-1:0]   cnt_q;

   logic [2:0]      size_m1;
   logic            misaligned;
   logic            oversize;
   logic            req_bad;
   logic [OW-1:0]   in_off;
   logic [NB-1:0]   in_wmask;
   logic [DW-1:0]   in_keep;
   logic [DW-1:0]   in_wdata_sh;
   logic            timed_out;

   logic [DW-1:0]   resp_shifted;
   logic [DW-1:0]   resp_keep;
   logic            resp_sign;
   logic [DW-1:0]   load_data;

   // Decode the incoming request: alignment/size legality, the byte-lane
   // mask and the store data moved onto its lanes. The alignment test looks
   // at three address bits so a 64-bit access on a 32-bit bus is still
   // checked for alignment even though it will be rejected as oversize.
   always_comb begin
      size_m1     = 3'((4'd1 << in_wdt) - 4'd1);
      misaligned  = |(in_addr[2:0] & size_m1);
      oversize    = (32'd8 << in_wdt) > 32'(DW);
      req_bad     = misaligned | oversize;
      in_off      = in_addr[OW-1:0];
      in_wmask    = '0;
      in_keep     = '0;
      for (int i = 0; i < NB; i++) begin
         in_wmask[i] = (i >= int'(in_off)) && (i < int'(in_off) + (1 << in_wdt));
      end
      for (int i = 0; i < DW; i++) begin
         in_keep[i] = (i < (8 << in_wdt));
      end
      in_wdata_sh = (in_wdata & in_keep) << {in_off, 3'b000};
   end

   // Pull the addressed bytes out of the returned word and extend them.
   // The sign bit index is clamped so an illegal width can never index
   // past the top of the bus.
   always_comb begin
      int nbits;
      int sign_idx;
      nbits        = 8 << wdt_q;
      sign_idx     = (nbits > DW) ? DW - 1 : nbits - 1;
      resp_shifted = mem_resp_rdata >> {off_q, 3'b000};
      resp_keep    = '0;
      for (int i = 0; i < DW; i++) begin
         resp_keep[i] = (i < nbits);
      end
      resp_sign    = sext_q & resp_shifted[sign_idx];
      load_data    = (resp_shifted & resp_keep) | ({DW{resp_sign}} & ~resp_keep);
   end

   assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Illegal requests skip the memory entirely; in WAIT a
   // response beats a simultaneous timeout.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (in_valid) next_state = req_bad ? DONE : ISSUE;
         ISSUE: if (mem_req_ready) next_state = WAIT;
         WAIT:  if (mem_resp_valid || timed_out) next_state = DONE;
         DONE:  if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Captured request fields, the WAIT timeout counter and the response.
   // The request is latched once in IDLE so the memory side sees stable
   // fields for as long as it back-pressures ISSUE.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdt_q   <= '0;
         sext_q  <= 1'b0;
         off_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  wen_q   <= in_wen;
                  addr_q  <= in_addr & ~AW'(NB - 1);
                  wdt_q   <= in_wdt;
                  sext_q  <= in_sext;
                  off_q   <= in_off;
                  wdata_q <= in_wdata_sh;
                  wmask_q <= in_wmask;
                  rdata_q <= '0;
                  err_q   <= req_bad;
                  cnt_q   <= '0;
               end
            end
            ISSUE: begin
               if (mem_req_ready) cnt_q <= '0;
            end
            WAIT: begin
               cnt_q <= cnt_q + CW'(1);
               if (mem_resp_valid) begin
                  err_q   <= 1'b0;
                  rdata_q <= wen_q ? '0 : load_data;
               end else if (timed_out) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs. Everything is forced to zero while reset is held so the
   // reset values appear immediately, not one edge later.
   always_comb begin
      in_ready      = !rst && (state == IDLE);
      out_valid     = !rst && (state == DONE);
      mem_req_valid = !rst && (state == ISSUE);
      out_rdata     = rst ? '0 : rdata_q;
      out_err       = !rst && err_q;
      mem_req_wen   = !rst && wen_q;
      mem_req_addr  = rst ? '0 : addr_q;
      mem_req_wdata = rst ? '0 : wdata_q;
      mem_req_wmask = rst ? '0 : wmask_q;
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//   Scoreboard bench: the stimulus process predicts each response from a
//   byte-array memory model and queues it; a memory responder plays the
//   memory port from per-transaction plans; a monitor pops and compares
//   every response the DUT hands back.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

   localparam int          TO   = 4;
   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

   typedef struct {
      int          off;
      int          size;
      logic        wen;
      logic [63:0] wdata;
      int          stall;
      int          delay;
      bit          abort;
      logic [63:0] exp_addr;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_wmask;
   } plan_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, in_wen, in_sext;
   logic [63:0] in_addr, in_wdata;
   logic [1:0]  in_wdt;
   logic        out_valid, out_ready, out_err;
   logic [63:0] out_rdata;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;

   logic        in_valid32, in_ready32, in_wen32, in_sext32;
   logic [31:0] in_addr32, in_wdata32;
   logic [1:0]  in_wdt32;
   logic        out_valid32, out_ready32, out_err32;
   logic [31:0] out_rdata32;
   logic        mem_req_valid32, mem_req_wen32;
   logic [31:0] mem_req_addr32, mem_req_wdata32;
   logic [3:0]  mem_req_wmask32;

   plan_t       plan_q[$];
   exp_t        sb_q[$];
   logic [7:0]  mem [0:63];
   int          checks;
   int          failures;

   lsu_mem_ctrl #(.DW(64), .AW(64), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_wdt(in_wdt), .in_sext(in_sext),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rdata(out_rdata), .out_err(out_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
   );

   lsu_mem_ctrl #(.DW(32), .AW(32), .TIMEOUT(8)) dut32 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid32), .in_ready(in_ready32), .in_wen(in_wen32),
      .in_addr(in_addr32), .in_wdata(in_wdata32), .in_wdt(in_wdt32), .in_sext(in_sext32),
      .out_valid(out_valid32), .out_ready(out_ready32),
      .out_rdata(out_rdata32), .out_err(out_err32),
      .mem_req_valid(mem_req_valid32), .mem_req_ready(1'b1),
      .mem_req_wen(mem_req_wen32), .mem_req_addr(mem_req_addr32),
      .mem_req_wdata(mem_req_wdata32), .mem_req_wmask(mem_req_wmask32),
      .mem_resp_valid(1'b0), .mem_resp_rdata(32'h0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: count it, and report it if the values differ.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic summary();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
   endtask

   function automatic logic [63:0] memWord(input int base8);
      logic [63:0] w;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = mem[base8 + b];
      return w;
   endfunction

   // Reference load: little-endian bytes from the model memory, extended.
   function automatic logic [63:0] loadExpect(input int off, input int size, input logic sext);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mem[off + i];
      if (sext && v[8*size-1]) begin
         for (int i = 8*size; i < 64; i++) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Present one request, wait (bounded) for acceptance, and record what the
   // memory should see and what the response should be.
   task automatic applyStimulus(input logic wen, input int off, input int wdt,
                                input logic [63:0] wdata, input logic sext,
                                input int stall, input int delay, input bit abort);
      int    size;
      int    n;
      plan_t p;
      exp_t  e;
      size     = 1 << wdt;
      in_valid = 1'b1;
      in_wen   = wen;
      in_addr  = BASE + 64'(off);
      in_wdata = wdata;
      in_wdt   = 2'(wdt);
      in_sext  = sext;
      n = 0;
      while (!in_ready && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checkOutput("accept_wait", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      if ((off % size) != 0) begin
         e.rdata = '0;
         e.err   = 1'b1;
      end else begin
         p.off       = off;
         p.size      = size;
         p.wen       = wen;
         p.wdata     = wdata;
         p.stall     = stall;
         p.delay     = delay;
         p.abort     = abort;
         p.exp_addr  = (BASE + 64'(off)) & ~64'd7;
         p.exp_wdata = '0;
         p.exp_wmask = '0;
         for (int i = 0; i < size; i++) begin
            p.exp_wmask[(off % 8) + i]           = 1'b1;
            p.exp_wdata[8*((off % 8) + i) +: 8] = wdata[8*i +: 8];
         end
         plan_q.push_back(p);
         if (delay >= TO) begin
            e.rdata = '0;
            e.err   = 1'b1;
         end else begin
            e.rdata = wen ? 64'd0 : loadExpect(off, size, sext);
            e.err   = 1'b0;
         end
      end
      sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Memory responder: checks each request against its plan, applies the
   // planned back-pressure and response delay, and updates model memory on
   // a store acknowledge. Timed-out plans get a late stray response.
   initial begin
      plan_t p;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b0;
         if (mem_req_valid && !rst) begin
            if (plan_q.size() == 0) begin
               checkOutput("unexpected_mem_req", 64'd1, 64'd0);
               mem_req_ready = 1'b1;
            end else begin
               p = plan_q.pop_front();
               checkOutput("mem_req_addr", mem_req_addr, p.exp_addr);
               checkOutput("mem_req_wen", 64'(mem_req_wen), 64'(p.wen));
               checkOutput("mem_req_wmask", 64'(mem_req_wmask), 64'(p.exp_wmask));
               if (p.wen) checkOutput("mem_req_wdata", mem_req_wdata, p.exp_wdata);
               for (int s = 0; s < p.stall; s++) begin
                  @(posedge clk); #1;
                  checkOutput("stall_req_valid", 64'(mem_req_valid), 64'd1);
                  checkOutput("stall_req_addr", mem_req_addr, p.exp_addr);
                  checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
               end
               mem_req_ready = 1'b1;
               @(posedge clk); #1;
               mem_req_ready = 1'b0;
               if (!p.abort) begin
                  if (p.delay < TO) begin
                     for (int d = 0; d < p.delay; d++) begin
                        @(posedge clk); #1;
                     end
                     if (p.wen) begin
                        for (int i = 0; i < p.size; i++) mem[p.off + i] = p.wdata[8*i +: 8];
                        mem_resp_rdata = 64'(p.off) ^ 64'hDEAD_BEEF_0BAD_F00D;
                     end else begin
                        mem_resp_rdata = memWord(p.off & ~7);
                     end
                     mem_resp_valid = 1'b1;
                  end else begin
                     for (int d = 0; d < TO; d++) begin
                        @(posedge clk); #1;
                     end
                     mem_resp_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
                     mem_resp_valid = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Response monitor with random out_ready back-pressure.
   initial begin
      exp_t e;
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            out_ready = 1'b0;
            continue;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_response", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("out_rdata", out_rdata, e.rdata);
               checkOutput("out_err", 64'(out_err), 64'(e.err));
            end
         end
      end
   end

   // Global time limit.
   initial begin
      #2000000;
      checkOutput("watchdog", 64'd1, 64'd0);
      summary();
      $finish;
   end

   // Main sequence: reset, directed cases, reset during WAIT, random mix,
   // 32-bit oversize case, drain.
   initial begin
      int          lat;
      int          n;
      int          wdt;
      int          off;
      bit          seen_req;
      logic [63:0] w;
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      in_valid   = 1'b0; in_wen = 1'b0; in_addr = '0; in_wdata = '0; in_wdt = '0; in_sext = 1'b0;
      in_valid32 = 1'b0; in_wen32 = 1'b0; in_addr32 = '0; in_wdata32 = '0; in_wdt32 = '0;
      in_sext32  = 1'b0; out_ready32 = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      checkOutput("rst_out_err", 64'(out_err), 64'd0);
      checkOutput("rst_out_rdata", out_rdata, 64'd0);
      checkOutput("rst_mem_req_wmask", 64'(mem_req_wmask), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

      $display("[TB] directed cases");
      w = 64'h1122334455667788;
      for (int b = 0; b < 8; b++) mem[8 + b] = w[8*b +: 8];
      applyStimulus(1'b0, 8, 3, 64'd0, 1'b0, 0, 0, 1'b0);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("load_latency", 64'(lat), 64'd3);

      w = 64'h0000F30000000000;
      for (int b = 0; b < 8; b++) mem[b] = w[8*b +: 8];
      applyStimulus(1'b0, 5, 0, 64'd0, 1'b1, 0, 1, 1'b0);
      applyStimulus(1'b0, 5, 0, 64'd0, 1'b0, 1, 0, 1'b0);
      applyStimulus(1'b1, 6, 1, 64'h00000000ABCD1234, 1'b0, 5, 2, 1'b0);
      applyStimulus(1'b0, 2, 2, 64'd0, 1'b0, 0, 0, 1'b0);
      applyStimulus(1'b0, 16, 3, 64'd0, 1'b0, 0, TO + 2, 1'b0);
      applyStimulus(1'b1, 24, 2, 64'h1234567890ABCDEF, 1'b0, 0, TO + 1, 1'b0);

      $display("[TB] reset during WAIT");
      applyStimulus(1'b0, 32, 3, 64'd0, 1'b0, 0, 0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("midrst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      rst = 1'b0;
      if (sb_q.size() > 0) void'(sb_q.pop_back());
      @(posedge clk); #1;
      checkOutput("postrst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("postrst_out_valid", 64'(out_valid), 64'd0);
      applyStimulus(1'b0, 8, 3, 64'd0, 1'b0, 0, 0, 1'b0);

      $display("[TB] random transactions");
      for (int t = 0; t < 300; t++) begin
         wdt = $urandom_range(0, 3);
         off = $urandom_range(0, 63);
         if ($urandom_range(0, 4) != 0) off = off & ~((1 << wdt) - 1);
         applyStimulus(1'($urandom_range(0, 1)), off, wdt, {$urandom, $urandom},
                       1'($urandom_range(0, 1)), $urandom_range(0, 3),
                       $urandom_range(0, 5), 1'b0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("[TB] 32-bit bus oversize access");
      seen_req   = 1'b0;
      in_valid32 = 1'b1;
      in_wdt32   = 2'd3;
      in_addr32  = 32'h0000_1000;
      n = 0;
      while (!in_ready32 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      n = 0;
      while (!out_valid32 && n < 20) begin
         if (mem_req_valid32) seen_req = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      checkOutput("dw32_out_valid", 64'(out_valid32), 64'd1);
      checkOutput("dw32_out_err", 64'(out_err32), 64'd1);
      checkOutput("dw32_out_rdata", 64'(out_rdata32), 64'd0);
      checkOutput("dw32_no_mem_req", 64'(seen_req), 64'd0);

      n = 0;
      while ((sb_q.size() != 0 || plan_q.size() != 0) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drain_scoreboard", 64'(sb_q.size()), 64'd0);
      checkOutput("drain_plans", 64'(plan_q.size()), 64'd0);
      summary();
      $finish;
   end

endmodule
